// File: rtl/pcm_record_capture.sv
// Record-path capture: button-armed FSM feeding codec frames (mono average or left) into a sample FIFO.
// Optional peak-magnitude tracker enabled by defining PCM_CAPTURE_PEAK_EN.
//
// state   | meaning
// IDLE    | not recording, FIFO may still drain
// ARMED   | waiting for the first codec frame
// CAPTURE | every rec_valid writes one sample
module pcm_record_capture #(
    parameter int DEPTH_LOG2 = 10,
    parameter int AVG_STEREO = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  record_button,
    input  logic                  rec_valid,
    input  logic [15:0]           rec_left,
    input  logic [15:0]           rec_right,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  capturing,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   count,
    output logic [15:0]           peak_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t                state;
    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [16:0]           sum_w;
    logic [15:0]           sample;
    logic                  write_req;
    logic                  do_write;
    logic                  pop;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // 17-bit sum cannot overflow; dropping bit 0 is an arithmetic shift that floors.
    always_comb begin
        sum_w  = {rec_left[15], rec_left} + {rec_right[15], rec_right};
        sample = (AVG_STEREO != 0) ? sum_w[16:1] : rec_left;
    end

    // The button wins over a frame arriving while ARMED.
    assign write_req = rec_valid &&
                       ((state == CAPTURE) || (state == ARMED && !record_button));
    assign pop       = rd_en && !empty;
    assign do_write  = write_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            capturing <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (record_button) begin
                        state    <= ARMED;
                        overflow <= 1'b0;
                    end
                end
                ARMED: begin
                    if (record_button) begin
                        state <= IDLE;
                    end else if (rec_valid) begin
                        state     <= CAPTURE;
                        capturing <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (record_button) begin
                        state     <= IDLE;
                        capturing <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    capturing <= 1'b0;
                end
            endcase
            if (write_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (do_write)
                wr_ptr <= wr_ptr + PTR_ONE;
            case ({do_write, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef PCM_CAPTURE_PEAK_EN
    logic [15:0] mag;

    // -32768 has no positive counterpart; clamp it.
    always_comb begin
        if (!sample[15])
            mag = sample;
        else if (sample == 16'h8000)
            mag = 16'h7fff;
        else
            mag = ~sample + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            peak_out <= '0;
        else if (state == IDLE && record_button)
            peak_out <= '0;
        else if (do_write && mag > peak_out)
            peak_out <= mag;
    end
`else
    assign peak_out = '0;
`endif

endmodule

// File: tb/tb_pcm_record_capture.sv
// Directed bench for pcm_record_capture: a default-depth instance and a depth-4 instance for full/overflow cases.
module tb_pcm_record_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_btn, a_rv, a_rd;
    logic [15:0] a_l, a_r, a_rd_data, a_peak;
    logic        a_rd_valid, a_capturing, a_full, a_empty, a_overflow;
    logic [10:0] a_count;

    logic        b_btn, b_rv, b_rd;
    logic [15:0] b_l, b_r, b_rd_data, b_peak;
    logic        b_rd_valid, b_capturing, b_full, b_empty, b_overflow;
    logic [2:0]  b_count;

    int checks   = 0;
    int failures = 0;

    pcm_record_capture dut_a (
        .clk(clk), .reset(reset), .record_button(a_btn), .rec_valid(a_rv),
        .rec_left(a_l), .rec_right(a_r), .rd_en(a_rd), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .capturing(a_capturing), .full(a_full),
        .empty(a_empty), .overflow(a_overflow), .count(a_count), .peak_out(a_peak)
    );

    pcm_record_capture #(.DEPTH_LOG2(2), .AVG_STEREO(1)) dut_b (
        .clk(clk), .reset(reset), .record_button(b_btn), .rec_valid(b_rv),
        .rec_left(b_l), .rec_right(b_r), .rd_en(b_rd), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .capturing(b_capturing), .full(b_full),
        .empty(b_empty), .overflow(b_overflow), .count(b_count), .peak_out(b_peak)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_press;
        a_btn = 1'b1; tick(); a_btn = 1'b0;
    endtask

    task automatic a_frame(input logic [15:0] l, input logic [15:0] r);
        a_rv = 1'b1; a_l = l; a_r = r; tick(); a_rv = 1'b0;
    endtask

    task automatic a_pop;
        a_rd = 1'b1; tick(); a_rd = 1'b0;
    endtask

    task automatic b_press;
        b_btn = 1'b1; tick(); b_btn = 1'b0;
    endtask

    task automatic b_frame(input logic [15:0] v);
        b_rv = 1'b1; b_l = v; b_r = v; tick(); b_rv = 1'b0;
    endtask

    task automatic b_pop;
        b_rd = 1'b1; tick(); b_rd = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; a_btn = 1'b1; a_rv = 1'b1; a_rd = 1'b1; a_l = 16'd5; a_r = 16'd5;
        tick(); tick();
        checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", a_empty); end
        checks++; if (a_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", a_full); end
        checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", a_overflow); end
        checks++; if (a_capturing !== 1'b0) begin failures++; $display("FAIL reset_capturing got=%b exp=0", a_capturing); end
        checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", a_rd_valid); end
        checks++; if (a_rd_data !== 16'h0000) begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", a_rd_data); end
        checks++; if (a_peak !== 16'h0000) begin failures++; $display("FAIL reset_peak got=%h exp=0000", a_peak); end
        checks++; if (a_count !== 11'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        checks++; if (b_empty !== 1'b1 || b_count !== 3'd0) begin failures++; $display("FAIL reset_b got empty=%b count=%0d exp 1/0", b_empty, b_count); end
        a_btn = 1'b0; a_rv = 1'b0; a_rd = 1'b0; reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        a_press();
        checks++; if (a_capturing !== 1'b0) begin failures++; $display("FAIL armed_capturing got=%b exp=0", a_capturing); end
        a_frame(16'd100, 16'd300);
        checks++; if (a_capturing !== 1'b1) begin failures++; $display("FAIL first_frame_capturing got=%b exp=1", a_capturing); end
        checks++; if (a_count !== 11'd1 || a_empty !== 1'b0) begin failures++; $display("FAIL first_frame_count got=%0d empty=%b exp=1/0", a_count, a_empty); end
        a_frame(16'd100, 16'd300);
        a_frame(16'd100, 16'd300);
        checks++; if (a_count !== 11'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", a_count); end
        for (int i = 0; i < 3; i++) begin
            a_pop();
            checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 16'd200) begin failures++; $display("FAIL basic_pop%0d got valid=%b data=%h exp 1/00c8", i, a_rd_valid, a_rd_data); end
        end
        tick();
        checks++; if (a_rd_valid !== 1'b0 || a_empty !== 1'b1) begin failures++; $display("FAIL basic_after got valid=%b empty=%b exp 0/1", a_rd_valid, a_empty); end
    endtask

    task automatic test_average;
        logic [15:0] exp_s [5];
        logic [15:0] exp_peak;
        exp_s[0] = 16'hffff; exp_s[1] = 16'h0001; exp_s[2] = 16'hfffe;
        exp_s[3] = 16'h8000; exp_s[4] = 16'h7fff;
        a_frame(16'hffff, 16'h0000);
        a_frame(16'h0003, 16'h0000);
        a_frame(16'hfffd, 16'h0000);
        a_frame(16'h8000, 16'h8000);
`ifdef PCM_CAPTURE_PEAK_EN
        exp_peak = 16'h7fff;
`else
        exp_peak = 16'h0000;
`endif
        checks++; if (a_peak !== exp_peak) begin failures++; $display("FAIL peak_min got=%h exp=%h", a_peak, exp_peak); end
        a_frame(16'h7fff, 16'h7fff);
        checks++; if (a_count !== 11'd5) begin failures++; $display("FAIL avg_count got=%0d exp=5", a_count); end
        for (int i = 0; i < 5; i++) begin
            a_pop();
            checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== exp_s[i]) begin failures++; $display("FAIL avg_pop%0d got valid=%b data=%h exp 1/%h", i, a_rd_valid, a_rd_data, exp_s[i]); end
        end
        a_pop();
        checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 16'h7fff || a_overflow !== 1'b0) begin failures++; $display("FAIL pop_empty got valid=%b data=%h ovf=%b exp 0/7fff/0", a_rd_valid, a_rd_data, a_overflow); end
    endtask

    task automatic test_button_race;
        a_press();
        checks++; if (a_capturing !== 1'b0) begin failures++; $display("FAIL stop_capturing got=%b exp=0", a_capturing); end
        a_press();
        a_btn = 1'b1; a_rv = 1'b1; a_l = 16'd50; a_r = 16'd50;
        tick();
        a_btn = 1'b0; a_rv = 1'b0;
        checks++; if (a_count !== 11'd0 || a_capturing !== 1'b0) begin failures++; $display("FAIL race got count=%0d capturing=%b exp 0/0", a_count, a_capturing); end
        a_frame(16'd50, 16'd50);
        checks++; if (a_count !== 11'd0) begin failures++; $display("FAIL race_idle got count=%0d exp=0", a_count); end
    endtask

    task automatic test_drain_idle;
        a_press();
        a_frame(16'd10, 16'd10);
        a_frame(16'd20, 16'd20);
        a_press();
        checks++; if (a_capturing !== 1'b0 || a_count !== 11'd2) begin failures++; $display("FAIL idle_keep got capturing=%b count=%0d exp 0/2", a_capturing, a_count); end
        a_pop();
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 16'd10) begin failures++; $display("FAIL idle_pop0 got valid=%b data=%h exp 1/000a", a_rd_valid, a_rd_data); end
        a_pop();
        checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 16'd20) begin failures++; $display("FAIL idle_pop1 got valid=%b data=%h exp 1/0014", a_rd_valid, a_rd_data); end
    endtask

    task automatic test_reset_mid;
        a_press();
        for (int i = 1; i <= 7; i++) a_frame(16'(i), 16'(i));
        checks++; if (a_count !== 11'd7) begin failures++; $display("FAIL mid_count got=%0d exp=7", a_count); end
        a_rd = 1'b1;
        tick();
        reset = 1'b1; a_rv = 1'b1; a_btn = 1'b1;
        tick();
        reset = 1'b0; a_rv = 1'b0; a_btn = 1'b0; a_rd = 1'b0;
        checks++; if (a_count !== 11'd0 || a_empty !== 1'b1 || a_capturing !== 1'b0 || a_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got count=%0d empty=%b cap=%b valid=%b exp 0/1/0/0", a_count, a_empty, a_capturing, a_rd_valid); end
        a_pop();
        checks++; if (a_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_pop got valid=%b exp=0", a_rd_valid); end
        a_frame(16'd9, 16'd9);
        checks++; if (a_count !== 11'd0) begin failures++; $display("FAIL mid_idle got count=%0d exp=0", a_count); end
    endtask

    task automatic test_overflow;
        b_press();
        for (int v = 1; v <= 5; v++) begin
            b_frame(16'(v));
            if (v == 4) begin
                checks++; if (b_full !== 1'b1 || b_overflow !== 1'b0) begin failures++; $display("FAIL full4 got full=%b ovf=%b exp 1/0", b_full, b_overflow); end
            end
        end
        checks++; if (b_overflow !== 1'b1 || b_count !== 3'd4 || b_capturing !== 1'b1) begin failures++; $display("FAIL ovf5 got ovf=%b count=%0d cap=%b exp 1/4/1", b_overflow, b_count, b_capturing); end
    endtask

    task automatic test_full_wr_rd;
        logic [15:0] exp_s [4];
        exp_s[0] = 16'd2; exp_s[1] = 16'd3; exp_s[2] = 16'd4; exp_s[3] = 16'd6;
        b_rv = 1'b1; b_l = 16'd6; b_r = 16'd6; b_rd = 1'b1;
        tick();
        b_rv = 1'b0; b_rd = 1'b0;
        checks++; if (b_count !== 3'd4 || b_full !== 1'b1 || b_rd_valid !== 1'b1 || b_rd_data !== 16'd1) begin failures++; $display("FAIL full_wr_rd got count=%0d full=%b valid=%b data=%h exp 4/1/1/0001", b_count, b_full, b_rd_valid, b_rd_data); end
        for (int i = 0; i < 4; i++) begin
            b_pop();
            checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== exp_s[i]) begin failures++; $display("FAIL full_pop%0d got valid=%b data=%h exp 1/%h", i, b_rd_valid, b_rd_data, exp_s[i]); end
        end
        checks++; if (b_empty !== 1'b1 || b_overflow !== 1'b1) begin failures++; $display("FAIL drained got empty=%b ovf=%b exp 1/1", b_empty, b_overflow); end
    endtask

    task automatic test_empty_wr_rd;
        b_rv = 1'b1; b_l = 16'd7; b_r = 16'd7; b_rd = 1'b1;
        tick();
        b_rv = 1'b0; b_rd = 1'b0;
        checks++; if (b_count !== 3'd1 || b_rd_valid !== 1'b0) begin failures++; $display("FAIL empty_wr_rd got count=%0d valid=%b exp 1/0", b_count, b_rd_valid); end
        b_pop();
        checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 16'd7) begin failures++; $display("FAIL empty_wr_rd_pop got valid=%b data=%h exp 1/0007", b_rd_valid, b_rd_data); end
    endtask

    task automatic test_overflow_clear;
        b_press();
        checks++; if (b_overflow !== 1'b1 || b_capturing !== 1'b0) begin failures++; $display("FAIL ovf_hold got ovf=%b cap=%b exp 1/0", b_overflow, b_capturing); end
        b_press();
        checks++; if (b_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", b_overflow); end
    endtask

    initial begin
        reset = 1'b1;
        a_btn = 1'b0; a_rv = 1'b0; a_rd = 1'b0; a_l = '0; a_r = '0;
        b_btn = 1'b0; b_rv = 1'b0; b_rd = 1'b0; b_l = '0; b_r = '0;
        test_reset();
        test_basic();
        test_average();
        test_button_race();
        test_drain_idle();
        test_reset_mid();
        test_overflow();
        test_full_wr_rd();
        test_empty_wr_rd();
        test_overflow_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
